// File: rtl/bin_to_seg_scanner.sv
// bin_to_seg_scanner: binary-to-BCD converter (iterative double-dabble, one
// bit per clock) driving NUM_DIGITS multiplexed active-low seven-segment digits.
// Values that do not fit in NUM_DIGITS decimal digits are flagged and shown
// as dashes on every digit.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero shown digit (digit 0 is never blanked).
module bin_to_seg_scanner #(
  parameter int DATA_W     = 12,
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_W  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     value_in,
  input  logic                  value_valid,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            display,
  output logic [NUM_DIGITS-1:0] digit
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Double-dabble correction: every nibble holding 5..9 gets +3 before the shift
  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // BCD nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       work_q, work_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sticky_q, sticky_d;
  logic [BCD_W-1:0]        shown_q, shown_d;
  logic                    ovf_q, ovf_d;
  logic [BCD_W-1:0]        adj;

  logic [REFRESH_W-1:0]    refresh_q, refresh_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              display_q, display_d;
  logic [NUM_DIGITS-1:0]   digit_q, digit_d;
  logic [3:0]              nib;

  // Conversion FSM: next state, working registers, and result hand-off
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    shown_d  = shown_q;
    ovf_d    = ovf_q;
    adj      = '0;
    case (state_q)
      IDLE: begin
        if (value_valid) begin
          work_d   = value_in;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(DATA_W);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        adj    = add3_all(bcd_q);
        bcd_d  = {adj[BCD_W-2:0], work_q[DATA_W-1]};
        work_d = work_q << 1;
        // A 1 leaving the top digit means the value needs more digits than we have
        if (adj[BCD_W-1]) sticky_d = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        shown_d = bcd_q;
        ovf_d   = sticky_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible-result state, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shown_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shown_q <= shown_d;
      ovf_q   <= ovf_d;
    end
  end

  // Working datapath registers; always reloaded on acceptance, so no reset
  always_ff @(posedge clk) begin
    work_q   <= work_d;
    bcd_q    <= bcd_d;
    cnt_q    <= cnt_d;
    sticky_q <= sticky_d;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  above_zero;

  // A digit is blank when it and every digit above it are zero (digit 0 never)
  always_comb begin
    blank      = '0;
    above_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      above_zero = above_zero && (shown_q[i*4 +: 4] == 4'd0);
      blank[i]   = above_zero && (i != 0);
    end
  end
`endif

  // Scan: free-running refresh counter, digit index, and next strobe/segments
  always_comb begin
    refresh_d = refresh_q + REFRESH_W'(1);
    idx_d     = idx_q;
    if (&refresh_q) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    nib     = 4'd0;
    digit_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(idx_q) == i) begin
        nib        = shown_q[i*4 +: 4];
        digit_d[i] = 1'b0;
      end
    end
    if (ovf_q) begin
      display_d = SEG_DASH;
    end else begin
      display_d = seg_decode(nib);
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (int'(idx_q) == i && blank[i]) display_d = SEG_BLANK;
      end
`endif
    end
  end

  // Scan registers; outputs trail the index by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_q <= '0;
      idx_q     <= '0;
      display_q <= SEG_BLANK;
      digit_q   <= '1;
    end else begin
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      display_q <= display_d;
      digit_q   <= digit_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
  assign display  = display_q;
  assign digit    = digit_q;

endmodule

// File: tb/tb_bin_to_seg_scanner.sv
// Directed bench for bin_to_seg_scanner: a 4-digit and a 3-digit instance,
// both with a 3-bit refresh counter so every digit is strobed within 32 cycles.
module tb_bin_to_seg_scanner;

  localparam int DATA_W = 12;
  localparam int RW     = 3;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] v4 = '0, v3 = '0;
  logic              vv4 = 1'b0, vv3 = 1'b0;
  logic              busy4, ovf4, busy3, ovf3;
  logic [6:0]        disp4, disp3;
  logic [3:0]        dig4;
  logic [2:0]        dig3;

  int checks = 0;
  int passes = 0;

  logic [6:0] seg4 [4];
  logic [6:0] seg3 [3];

  always #5 clk = ~clk;

  bin_to_seg_scanner #(.DATA_W(DATA_W), .NUM_DIGITS(4), .REFRESH_W(RW)) dut4 (
    .clk(clk), .rst(rst), .value_in(v4), .value_valid(vv4),
    .busy(busy4), .overflow(ovf4), .display(disp4), .digit(dig4)
  );

  bin_to_seg_scanner #(.DATA_W(DATA_W), .NUM_DIGITS(3), .REFRESH_W(RW)) dut3 (
    .clk(clk), .rst(rst), .value_in(v3), .value_valid(vv3),
    .busy(busy3), .overflow(ovf3), .display(disp3), .digit(dig3)
  );

  // Record the segments seen while each digit of dut4 is strobed
  task automatic capture4();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) seg4[i] = 'x;
    repeat (72) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        m = 4'b0001 << i;
        if (dig4 == ~m) seg4[i] = disp4;
      end
    end
  endtask

  task automatic capture3();
    logic [2:0] m;
    for (int i = 0; i < 3; i++) seg3[i] = 'x;
    repeat (56) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        m = 3'b001 << i;
        if (dig3 == ~m) seg3[i] = disp3;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy4 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy4); else passes++;
    checks++; if (ovf4 !== 1'b0) $display("FAIL reset_overflow: got %b want 0", ovf4); else passes++;
    checks++; if (dig4 !== 4'b1111) $display("FAIL reset_digit: got %b want 1111", dig4); else passes++;
    checks++; if (disp4 !== 7'b1111111) $display("FAIL reset_display: got %b want 1111111", disp4); else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (dig4 !== 4'b1110) $display("FAIL first_scan_digit: got %b want 1110", dig4); else passes++;
    checks++; if (disp4 !== 7'b1000000) $display("FAIL first_scan_display: got %b want 1000000", disp4); else passes++;
  endtask

  task automatic test_convert_1234();
    int n;
    logic [6:0] exp [4];
    @(negedge clk); v4 = 12'd1234; vv4 = 1'b1;
    @(negedge clk); vv4 = 1'b0;
    n = 0;
    while (busy4 && n < 100) begin n++; @(negedge clk); end
    checks++; if (n != 13) $display("FAIL conv1234_busy_cycles: got %0d want 13", n); else passes++;
    checks++; if (ovf4 !== 1'b0) $display("FAIL conv1234_overflow: got %b want 0", ovf4); else passes++;
    @(negedge clk);
    capture4();
    exp = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seg4[i] !== exp[i]) $display("FAIL conv1234_digit%0d: got %b want %b", i, seg4[i], exp[i]);
      else passes++;
    end
  endtask

  task automatic test_overflow();
    int n;
    @(negedge clk); v3 = 12'd4095; vv3 = 1'b1;
    @(negedge clk); vv3 = 1'b0;
    n = 0;
    while (busy3 && n < 100) begin n++; @(negedge clk); end
    checks++; if (n != 13) $display("FAIL ovf_busy_cycles: got %0d want 13", n); else passes++;
    checks++; if (ovf3 !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ovf3); else passes++;
    @(negedge clk);
    capture3();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (seg3[i] !== 7'b0111111) $display("FAIL ovf_digit%0d: got %b want 0111111", i, seg3[i]);
      else passes++;
    end
  endtask

  task automatic test_reset_abort();
    int n;
    logic [6:0] exp [4];
    @(negedge clk); v4 = 12'd567; vv4 = 1'b1;
    @(negedge clk); vv4 = 1'b0;
    n = 0;
    while (busy4 && n < 5) begin n++; @(negedge clk); end
    rst = 1'b0;
    #1;
    checks++; if (busy4 !== 1'b0) $display("FAIL abort_busy_drop: got %b want 0", busy4); else passes++;
    checks++; if (dig4 !== 4'b1111) $display("FAIL abort_digit: got %b want 1111", dig4); else passes++;
    checks++; if (disp4 !== 7'b1111111) $display("FAIL abort_display: got %b want 1111111", disp4); else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    capture4();
    exp = '{7'b1000000, LZ, LZ, LZ};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seg4[i] !== exp[i]) $display("FAIL abort_zero_digit%0d: got %b want %b", i, seg4[i], exp[i]);
      else passes++;
    end
    @(negedge clk); v4 = 12'd8; vv4 = 1'b1;
    @(negedge clk); vv4 = 1'b0;
    n = 0;
    while (busy4 && n < 100) begin n++; @(negedge clk); end
    checks++; if (n != 13) $display("FAIL conv8_busy_cycles: got %0d want 13", n); else passes++;
    @(negedge clk);
    capture4();
    exp = '{7'b0000000, LZ, LZ, LZ};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seg4[i] !== exp[i]) $display("FAIL conv8_digit%0d: got %b want %b", i, seg4[i], exp[i]);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [6:0] exp [4];
    @(negedge clk); v4 = 12'd1234; vv4 = 1'b1;
    @(negedge clk); vv4 = 1'b0;
    n = 0;
    while (busy4 && n < 100) begin
      n++;
      if (n == 4) begin v4 = 12'd99; vv4 = 1'b1; end
      else vv4 = 1'b0;
      @(negedge clk);
    end
    vv4 = 1'b0;
    checks++; if (n != 13) $display("FAIL b2b_busy_cycles: got %0d want 13", n); else passes++;
    @(negedge clk);
    checks++; if (busy4 !== 1'b0) $display("FAIL b2b_no_requeue: busy got %b want 0", busy4); else passes++;
    capture4();
    exp = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seg4[i] !== exp[i]) $display("FAIL b2b_digit%0d: got %b want %b", i, seg4[i], exp[i]);
      else passes++;
    end
  endtask

  task automatic test_leading_zero();
    int n;
    logic [6:0] exp [4];
    @(negedge clk); v4 = 12'd7; vv4 = 1'b1;
    @(negedge clk); vv4 = 1'b0;
    n = 0;
    while (busy4 && n < 100) begin n++; @(negedge clk); end
    checks++; if (n != 13) $display("FAIL conv7_busy_cycles: got %0d want 13", n); else passes++;
    @(negedge clk);
    capture4();
    exp = '{7'b1111000, LZ, LZ, LZ};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seg4[i] !== exp[i]) $display("FAIL conv7_digit%0d: got %b want %b", i, seg4[i], exp[i]);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_convert_1234();
    test_overflow();
    test_reset_abort();
    test_back_to_back();
    test_leading_zero();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_seg_scanner.md
Name: bin_to_seg_scanner

Overview:
Parametrised successor to the fixed 4-digit hex-nibble seven-segment path. Accepts a binary value of configurable width and converts it to BCD sequentially using iterative double-dabble, so no combinational divide/modulo chains are needed. Drives a configurable number of multiplexed, active-low seven-segment digits and flags values too large to display. Sits between datapath sources (mouse coordinates, counters) and the board DISPLAY/DIGIT pins.

Parameters:
DATA_W, 12, width of the binary input value.
NUM_DIGITS, 4, number of displayed decimal digits, legal range 1..8.
REFRESH_W, 17, refresh counter width; the scan digit advances each time the counter wraps.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
value_in  input  DATA_W  binary value to display
value_valid  input  1  request a conversion of value_in
busy  output  1  conversion in progress; high means requests are ignored
overflow  output  1  last completed value is >= 10^NUM_DIGITS
display  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
digit  output  NUM_DIGITS  digit enables, active-low one-hot, registered; bit 0 is the rightmost (least significant) digit

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE; busy=0, overflow=0; display=7'b1111111; digit all ones; shown-BCD register=0; scan index=0; refresh counter=0.
- Conversion FSM states are IDLE, SHIFT and DONE.
- IDLE: if value_valid=1, latch value_in, clear the working BCD register (NUM_DIGITS*4 bits), clear the sticky overflow flag, load the shift count with DATA_W, then go to SHIFT. Otherwise stay in IDLE.
- SHIFT, one bit per cycle:
  - Every BCD nibble >= 5 first gets +3.
  - The BCD register then shifts left 1, taking in the MSB of the latched value; the latched value also shifts left.
  - Any 1 shifted out of the top BCD bit sets the sticky overflow flag.
  - The count decrements; when it reaches 1, go to DONE.
- DONE (1 cycle): copy the working BCD register to the shown-BCD register and the sticky flag to the overflow output, then go to IDLE.
- busy is high in SHIFT and DONE.
- Latency: with value_valid sampled at edge 0, the shown-BCD register and overflow update at edge DATA_W+1. busy is high from edge 1 to edge DATA_W+1, i.e. DATA_W+1 cycles.
- value_valid while busy=1 is ignored; it is not queued.
- value_valid in the same cycle DONE completes is ignored. It is accepted on the next IDLE cycle if still asserted.
- Scan:
  - The refresh counter is free-running.
  - When the counter equals all ones, the scan index increments; it wraps from NUM_DIGITS-1 to 0.
  - Every cycle, digit is registered as all ones except bit[index]=0, and display is registered as the decode of shown nibble[index]. Outputs therefore lag the index by one cycle.
- Decode (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Overflow: while overflow=1, every digit shows "-" (7'b0111111) regardless of the BCD contents.
- A new conversion does not disturb the shown value until its DONE cycle.
- Reset mid-conversion aborts it; the shown value becomes 0 and the outputs are as listed under Reset.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: any digit above the most significant nonzero shown digit outputs display=7'b1111111. The digit is still strobed normally. Digit 0 is never blanked, so a value of 0 shows a single "0". Blanking is not applied while overflow=1.
- Undefined: all digits display their decimal value, including leading zeros.

Test Plan:
Bench uses REFRESH_W=3.
- Reset: hold rst=0 for 3 cycles, release -> busy=0, overflow=0, digit=4'b1111 and display=7'b1111111 until the first scan cycle, then digit=4'b1110 with display=7'b1000000.
- DATA_W=12, NUM_DIGITS=4, value_in=1234 with a one-cycle value_valid:
  - busy is high for exactly 13 cycles.
  - The scan then shows digit0=0011001 (4), digit1=0110000 (3), digit2=0100100 (2), digit3=1111001 (1); overflow=0.
- NUM_DIGITS=3, value_in=4095 -> overflow=1 after 13 cycles; all three digits show 7'b0111111.
- Send value_in=1234, then value_valid with value_in=99 at busy cycle 4 -> the result still shows 1234; busy does not extend beyond 13 cycles.
- Send value_in=567, then assert rst=0 at busy cycle 5 -> busy drops immediately; after release, the shown value is 0 and a new request of 8 converts correctly.
- value_in=7:
  - With LEADING_ZERO_BLANK_EN: digits 1-3 show 7'b1111111 and digit0 shows 7'b1111000.
  - Without it: digits 1-3 show 7'b1000000.
